// File: rtl/adder_pkg.sv
// Shared constants and result type for the registered adder.
// Build option ADDER_SAT_EN (consumed by the top) selects a saturating q.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 64;
    localparam int CLA_GROUP     = 4;

    // Widest supported result; narrower adders zero-fill the upper sum bits.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] sum;
        logic                 carry;
        logic                 ovf;
    } adder_res_t;

    function automatic int cla_groups(input int width);
        return (width + CLA_GROUP - 1) / CLA_GROUP;
    endfunction

endpackage

// File: rtl/adder_cla.sv
// Combinational carry-lookahead core: 4-bit generate/propagate groups with the
// group carries rippled between them; the last group shrinks to fit WIDTH.
module adder_cla
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum_n,
    output logic             carry_n,
    output logic             ovf_n
);

    localparam int NGROUPS = cla_groups(WIDTH);

    for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
        localparam int LO = g * CLA_GROUP;
        localparam int GW = ((WIDTH - LO) < CLA_GROUP) ? (WIDTH - LO) : CLA_GROUP;

        logic [GW-1:0] w_p;
        logic [GW-1:0] w_g;
        logic [GW:0]   w_cc;
        logic          w_cin;
        logic          w_cout;
        logic          w_term;

        assign w_p = a[LO +: GW] ^ b[LO +: GW];
        assign w_g = a[LO +: GW] & b[LO +: GW];

        if (g == 0) begin : g_first
            assign w_cin = 1'b0;
        end else begin : g_rest
            assign w_cin = g_grp[g-1].w_cout;
        end

        // Each carry is a flat sum of products over this group's g/p terms,
        // so no carry inside the group depends on another in-group carry.
        always_comb begin
            w_cc   = '0;
            w_term = 1'b0;
            for (int i = 0; i <= GW; i++) begin
                w_term = w_cin;
                for (int k = 0; k < i; k++) begin
                    w_term = w_term & w_p[k];
                end
                w_cc[i] = w_term;
                for (int j = 0; j < i; j++) begin
                    w_term = w_g[j];
                    for (int k = j + 1; k < i; k++) begin
                        w_term = w_term & w_p[k];
                    end
                    w_cc[i] = w_cc[i] | w_term;
                end
            end
        end

        assign w_cout          = w_cc[GW];
        assign sum_n[LO +: GW] = w_p ^ w_cc[GW-1:0];
    end

    assign carry_n = g_grp[NGROUPS-1].w_cout;
    assign ovf_n   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_n[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/adder.sv
// Registered adder stage: one-cycle latency, carry and signed-overflow flags.
// Define ADDER_SAT_EN to clamp q to all ones whenever the sum carries out.
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             ovf
);

    // Handshake: in_valid qualifies a/b for one rising edge; there is no ready,
    // so every accepted pair yields out_valid for exactly one cycle, one edge later.

    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_ovf;
    adder_res_t       w_res;
    logic [WIDTH-1:0] w_q_next;

    logic [WIDTH-1:0] r_q;
    logic             r_carry;
    logic             r_ovf;
    logic             r_valid;

    adder_cla #(.WIDTH(WIDTH)) u_cla (
        .a       (a),
        .b       (b),
        .sum_n   (w_sum),
        .carry_n (w_carry),
        .ovf_n   (w_ovf)
    );

    always_comb begin
        w_res                = '0;
        w_res.sum[WIDTH-1:0] = w_sum;
        w_res.carry          = w_carry;
        w_res.ovf            = w_ovf;
    end

    if (WIDTH < MAX_WIDTH) begin : g_pad
        logic w_unused_pad;
        assign w_unused_pad = |w_res.sum[MAX_WIDTH-1:WIDTH];
    end

`ifdef ADDER_SAT_EN
    assign w_q_next = w_res.carry ? {WIDTH{1'b1}} : w_res.sum[WIDTH-1:0];
`else
    assign w_q_next = w_res.sum[WIDTH-1:0];
`endif

    // Reset wins over in_valid; idle cycles keep the last result visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_q     <= w_q_next;
                r_carry <= w_res.carry;
                r_ovf   <= w_res.ovf;
            end
        end
    end

    assign out_valid = r_valid;
    assign q         = r_q;
    assign carry     = r_carry;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_adder.sv
// Bench for adder: directed vectors with hand-computed results plus a full
// 4-bit operand sweep; a negedge monitor checks every cycle against the queue.
module tb_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic [W-1:0] q;
    logic         carry;
    logic         ovf;

    // Scoreboard entries are {q, carry, ovf}.
    logic [W+1:0] exp_q[$];
    logic [W+1:0] exp_hold = '0;
    logic         exp_vld  = 1'b0;
    logic         started  = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .q         (q),
        .carry     (carry),
        .ovf       (ovf)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0]   s;
        logic [W-1:0] qq;
        logic         o;
        s  = {1'b0, x} + {1'b0, y};
        o  = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        qq = s[W-1:0];
`ifdef ADDER_SAT_EN
        if (s[W]) qq = '1;
`endif
        return {qq, s[W], o};
    endfunction

    task automatic chk(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Driver: present one cycle of inputs, then record what the DUT owes us.
    task automatic drive(input logic r, input logic v, input logic [W-1:0] ta,
                         input logic [W-1:0] tbv, input logic [W+1:0] e);
        rst      = r;
        in_valid = v;
        a        = ta;
        b        = tbv;
        @(posedge clk);
        #1;
        exp_vld = v && !r;
        if (r) exp_hold = '0;
        else if (v) begin
            exp_hold = e;
            exp_q.push_back(e);
        end
        started = 1'b1;
    endtask

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic [W-1:0] q_wrap,
                      input logic [W-1:0] q_sat, input logic c, input logic o);
`ifdef ADDER_SAT_EN
        drive(1'b0, 1'b1, ta, tbv, {q_sat, c, o});
`else
        drive(1'b0, 1'b1, ta, tbv, {q_wrap, c, o});
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 4'h0, '0);
    endtask

    // Monitor
    initial begin
        logic [W+1:0] e;
        forever begin
            @(negedge clk);
            if (started) begin
                chk("out_valid", {5'd0, out_valid}, {5'd0, exp_vld});
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_result: got %h with empty queue at %0t", {q, carry, ovf}, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", {q, carry, ovf}, e);
                    end
                end else begin
                    chk("held", {q, carry, ovf}, exp_hold);
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [7:0] iv;
        // Reset with a live operand: must be discarded.
        drive(1'b1, 1'b1, 4'h5, 4'hA, '0);
        drive(1'b1, 1'b1, 4'h5, 4'hA, '0);

        //     a     b     q_wrap q_sat c     o
        op(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        op(4'h5, 4'hA, 4'hF, 4'hF, 1'b0, 1'b0);
        op(4'h7, 4'hA, 4'h1, 4'hF, 1'b1, 1'b0);
        op(4'h1, 4'hF, 4'h0, 4'hF, 1'b1, 1'b0);
        op(4'hF, 4'hF, 4'hE, 4'hF, 1'b1, 1'b0);
        op(4'h7, 4'h1, 4'h8, 4'h8, 1'b0, 1'b1);
        op(4'h8, 4'h8, 4'h0, 4'hF, 1'b1, 1'b1);

        // Hold after (5,A)
        op(4'h5, 4'hA, 4'hF, 4'hF, 1'b0, 1'b0);
        idle(3);

        // Reset mid-stream on the (F,F) edge, then first post-reset result.
        op(4'h3, 4'h4, 4'h7, 4'h7, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'hF, 4'hF, '0);
        idle(1);
        op(4'h2, 4'h3, 4'h5, 4'h5, 1'b0, 1'b0);
        idle(1);

        // Full operand sweep, back to back.
        for (int i = 0; i < 256; i++) begin
            iv = i[7:0];
            drive(1'b0, 1'b1, iv[7:4], iv[3:0], ref_model(iv[7:4], iv[3:0]));
        end
        idle(2);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size() > 63 ? 6'h3F : 6'(exp_q.size()), 6'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
